// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor:
// 2-bit counter encodings, the BTB entry view and saturating counter steps.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Widest tag occurs at the smallest table (4 entries); narrower tags are zero-extended.
  localparam int MAX_TAG_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic                 is_jump;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute-stage training and redirect signals of the branch predictor.
// upd_valid_e qualifies every upd_*/pred_*_e field for one cycle; there is no ready,
// the predictor accepts a resolved branch on every cycle it is presented.
interface branch_predictor_if;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        upd_valid_e;
  logic        upd_is_jump_e;
  logic [31:0] upd_pc_e;
  logic        upd_taken_e;
  logic [31:0] upd_target_e;
  logic [31:0] upd_pc_plus4_e;
  logic        pred_taken_e;
  logic [31:0] pred_pc_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  modport master (
    output pc_f, upd_valid_e, upd_is_jump_e, upd_pc_e, upd_taken_e,
           upd_target_e, upd_pc_plus4_e, pred_taken_e, pred_pc_e,
    input  pred_taken_f, pred_pc_f, mispredict_e, redirect_pc_e,
           perf_branches, perf_mispredicts
  );

  modport slave (
    input  pc_f, upd_valid_e, upd_is_jump_e, upd_pc_e, upd_taken_e,
           upd_target_e, upd_pc_plus4_e, pred_taken_e, pred_pc_e,
    output pred_taken_f, pred_pc_f, mispredict_e, redirect_pc_e,
           perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/bp_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: zero-cycle fetch prediction,
// execute-stage training, mispredict/redirect generation and perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic             jump_q   [ENTRIES];
  logic             jump_d   [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  btb_entry_t       f_ent;
  logic             f_hit, u_hit, f_taken;

  // Lookup reads only registered state, so a same-index update is seen next cycle.
  always_comb begin
    f_idx = bp.pc_f[IDX_W+1:2];
    f_ent = '{valid:   valid_q[f_idx],
              tag:     MAX_TAG_W'(tag_q[f_idx]),
              target:  target_q[f_idx],
              is_jump: jump_q[f_idx],
              ctr:     ctr_q[f_idx]};
    f_hit   = f_ent.valid && (f_ent.tag == MAX_TAG_W'(bp.pc_f[31:IDX_W+2]));
    f_taken = f_hit && (f_ent.is_jump || f_ent.ctr[1]);
  end

  assign bp.pred_taken_f = f_taken;
  assign bp.pred_pc_f    = f_taken ? f_ent.target : bp.pc_f + 32'd4;

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    jump_d   = jump_q;
    tag_d    = tag_q;
    target_d = target_q;
    u_idx    = bp.upd_pc_e[IDX_W+1:2];
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == bp.upd_pc_e[31:IDX_W+2]);
    if (bp.upd_valid_e) begin
      if (u_hit && bp.upd_taken_e) begin
        ctr_d[u_idx]    = sat_inc(ctr_q[u_idx]);
        target_d[u_idx] = bp.upd_target_e;
        jump_d[u_idx]   = bp.upd_is_jump_e;
      end else if (u_hit) begin
        ctr_d[u_idx] = sat_dec(ctr_q[u_idx]);
      end else if (bp.upd_taken_e) begin
        // Not-taken misses never allocate, so cold branches cost nothing.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = bp.upd_pc_e[31:IDX_W+2];
        target_d[u_idx] = bp.upd_target_e;
        jump_d[u_idx]   = bp.upd_is_jump_e;
        ctr_d[u_idx]    = bp.upd_is_jump_e ? ST : WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
        jump_q[i]  <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      jump_q  <= jump_d;
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign bp.mispredict_e  = bp.upd_valid_e &&
                            ((bp.pred_taken_e != bp.upd_taken_e) ||
                             (bp.upd_taken_e && (bp.pred_pc_e != bp.upd_target_e)));
  assign bp.redirect_pc_e = (bp.upd_valid_e && bp.upd_taken_e) ? bp.upd_target_e
                                                               : bp.upd_pc_plus4_e;

  bp_sat_counter32 u_perf_branches (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (bp.upd_valid_e),
    .cnt_o (bp.perf_branches)
  );

  bp_sat_counter32 u_perf_mispredicts (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (bp.mispredict_e),
    .cnt_o (bp.perf_mispredicts)
  );
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic,
// checked against a table model keyed by word address.
module tb_branch_predictor;
  localparam int ENTRIES = 16;

  typedef struct packed {
    logic        pt;
    logic [31:0] ppc;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] pb;
    logic [31:0] pm;
  } exp_t;

  logic clk, rst_n, chk_en;
  int   checks, errors;
  exp_t exp_q[$];

  bit          m_valid  [ENTRIES];
  logic [29:0] m_word   [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  bit          m_jump   [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_br, m_mp;

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference model
  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
      m_jump[i]  = 0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic pt, output logic [31:0] ppc);
    int idx;
    bit hit;
    idx = int'(pc[31:2] % ENTRIES);
    hit = m_valid[idx] && (m_word[idx] == pc[31:2]);
    pt  = hit && (m_jump[idx] || m_ctr[idx] >= 2);
    ppc = pt ? m_target[idx] : pc + 32'd4;
  endtask

  task automatic model_train(input logic [31:0] upc, input bit ij, input bit tk,
                             input logic [31:0] tgt, input bit mp);
    int idx;
    bit hit;
    idx = int'(upc[31:2] % ENTRIES);
    hit = m_valid[idx] && (m_word[idx] == upc[31:2]);
    if (hit && tk) begin
      m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
      m_target[idx] = tgt;
      m_jump[idx]   = ij;
    end else if (hit) begin
      m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
    end else if (tk) begin
      m_valid[idx]  = 1;
      m_word[idx]   = upc[31:2];
      m_target[idx] = tgt;
      m_jump[idx]   = ij;
      m_ctr[idx]    = ij ? 3 : 2;
    end
    if (m_br < 64'hFFFF_FFFF) m_br++;
    if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pred_taken_f",     32'(bp_if.pred_taken_f), 32'(e.pt));
        chk("pred_pc_f",        bp_if.pred_pc_f,         e.ppc);
        chk("mispredict_e",     32'(bp_if.mispredict_e), 32'(e.mp));
        chk("redirect_pc_e",    bp_if.redirect_pc_e,     e.rpc);
        chk("perf_branches",    bp_if.perf_branches,     e.pb);
        chk("perf_mispredicts", bp_if.perf_mispredicts,  e.pm);
      end
    end
  end

  // Driver: called at posedge+1, returns at the next posedge+1
  task automatic step(input logic [31:0] pc, input bit uv, input bit ij, input logic [31:0] upc,
                      input bit tk, input logic [31:0] tgt, input bit pte,
                      input logic [31:0] ppe, input bit mid_rst);
    exp_t e;
    if (!rst_n) rst_n = 1'b1;
    bp_if.pc_f           = pc;
    bp_if.upd_valid_e    = uv;
    bp_if.upd_is_jump_e  = ij;
    bp_if.upd_pc_e       = upc;
    bp_if.upd_taken_e    = tk;
    bp_if.upd_target_e   = tgt;
    bp_if.upd_pc_plus4_e = upc + 32'd4;
    bp_if.pred_taken_e   = pte;
    bp_if.pred_pc_e      = ppe;
    if (mid_rst) begin
      #1 rst_n = 1'b0;
      model_reset();
    end
    model_predict(pc, e.pt, e.ppc);
    e.mp  = uv && ((pte != tk) || (tk && ppe != tgt));
    e.rpc = (uv && tk) ? tgt : upc + 32'd4;
    e.pb  = m_br[31:0];
    e.pm  = m_mp[31:0];
    exp_q.push_back(e);
    chk_en = 1'b1;
    @(posedge clk);
    if (rst_n && uv) model_train(upc, ij, tk, tgt, e.mp);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    step(pc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] upc, tgt, pc, ppc, r;
    logic        pt;
    bit          ij, tk;
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    bp_if.pc_f = '0; bp_if.upd_valid_e = 0; bp_if.upd_is_jump_e = 0; bp_if.upd_pc_e = '0;
    bp_if.upd_taken_e = 0; bp_if.upd_target_e = '0; bp_if.upd_pc_plus4_e = '0;
    bp_if.pred_taken_e = 0; bp_if.pred_pc_e = '0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and allocation of a conditional branch
    look(32'h100);
    step(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    look(32'h100);
    // Hysteresis: 10 -> 01 -> 00, then back up and saturate at 11
    step(32'h100, 1, 0, 32'h100, 0, 32'h0, 1, 32'h80, 0);
    step(32'h100, 1, 0, 32'h100, 0, 32'h0, 0, 32'h104, 0);
    look(32'h100);
    step(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    look(32'h100);
    step(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0);
    look(32'h100);
    for (int i = 0; i < 3; i++) step(32'h100, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 0);
    step(32'h100, 1, 0, 32'h100, 0, 32'h0, 1, 32'h80, 0);
    look(32'h100);
    step(32'h100, 1, 0, 32'h100, 0, 32'h0, 1, 32'h80, 0);
    look(32'h100);
    // Alias replacement at the same index
    step(32'h140, 1, 0, 32'h140, 1, 32'h200, 0, 32'h144, 0);
    look(32'h100);
    look(32'h140);
    // Jump allocation, wrong target, read-before-write
    step(32'h20, 1, 1, 32'h20, 1, 32'h400, 0, 32'h24, 0);
    look(32'h20);
    step(32'h20, 1, 1, 32'h20, 1, 32'h404, 1, 32'h400, 0);
    look(32'h20);
    look(32'hFFFF_FFFC);
    // Async reset during an update; the next update applies normally
    step(32'h20, 1, 0, 32'h140, 1, 32'h300, 0, 32'h144, 1);
    look(32'h140);
    step(32'h140, 1, 0, 32'h140, 1, 32'h300, 0, 32'h144, 0);
    look(32'h140);

    // Random traffic over a small PC pool with aliasing high bits
    for (int n = 0; n < 300; n++) begin
      r   = $urandom;
      upc = {20'h0, r[31] ? 4'h1 : 4'h0, 8'h0} | {25'h0, r[4:0], 2'b00};
      r   = $urandom;
      tgt = {r[31:2], 2'b00};
      ij  = ($urandom_range(0, 5) == 0);
      tk  = ij || ($urandom_range(0, 2) != 0);
      model_predict(upc, pt, ppc);
      if ($urandom_range(0, 3) == 0) begin
        pt  = $urandom_range(0, 1) == 1;
        r   = $urandom;
        ppc = {r[31:2], 2'b00};
      end else if (tk && $urandom_range(0, 1) == 1 && pt) begin
        tgt = ppc;
      end
      r  = $urandom;
      pc = ($urandom_range(0, 1) == 1) ? upc : {20'h0, r[31] ? 4'h1 : 4'h0, 8'h0} | {25'h0, r[4:0], 2'b00};
      step(pc, $urandom_range(0, 3) != 0, ij, upc, tk, tgt, pt, ppc, 0);
    end

    chk_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Looks up the current fetch PC and produces pred_taken_f / pred_pc_f, which travel down the pipe as pred_taken_d / pred_pc_d into the ID/EX register.
- Is trained by the execute stage's branch/jump resolution.
- Produces the mispredict/redirect signal used to flush the front end.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 4..256.
IDX_W, $clog2(ENTRIES), index width; derived, not overridable.
TAG_W, 30-IDX_W, tag width; derived.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_f  in  32  current fetch PC (word aligned)
pred_taken_f  out  1  predicted taken for pc_f
pred_pc_f  out  32  predicted next PC for pc_f
upd_valid_e  in  1  execute stage holds a resolved branch or jump this cycle
upd_is_jump_e  in  1  resolved instruction is an unconditional jump (jal/jalr)
upd_pc_e  in  32  PC of the resolved instruction
upd_taken_e  in  1  actual outcome
upd_target_e  in  32  actual target when taken
upd_pc_plus4_e  in  32  fall-through PC
pred_taken_e  in  1  prediction carried with the instruction (pred_taken_e1 from ID/EX)
pred_pc_e  in  32  predicted PC carried with the instruction (pred_pc_e1 from ID/EX)
mispredict_e  out  1  redirect fetch and flush IF/ID and ID/EX
redirect_pc_e  out  32  correct next PC when mispredict_e=1
perf_branches  out  32  count of resolved updates
perf_mispredicts  out  32  count of mispredicts

Behaviour:
Addressing:
- index = pc[IDX_W+1:2]
- tag = pc[31:IDX_W+2]
- pc[1:0] is ignored.

Storage per entry: valid, tag[TAG_W], target[32], is_jump, ctr[2].

Lookup (combinational from registered state):
- hit = valid & tag match.
- pred_taken_f = hit & (is_jump | ctr[1]).
- pred_pc_f = pred_taken_f ? target : pc_f+4 (32-bit wrap).

Mispredict (combinational, gated by upd_valid_e):
- mispredict_e = upd_valid_e & ((pred_taken_e != upd_taken_e) | (upd_taken_e & pred_pc_e != upd_target_e)).
- redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_plus4_e.
- When upd_valid_e=0, mispredict_e=0 and redirect_pc_e is don't-care (drive upd_pc_plus4_e).

Update (registered, on clk rising edge when upd_valid_e=1), indexed by upd_pc_e:
- Hit, taken: ctr saturating +1 (max 11); target <= upd_target_e; is_jump <= upd_is_jump_e.
- Hit, not taken: ctr saturating -1 (min 00); target unchanged.
- Miss, taken: allocate/replace. valid=1, tag, target, is_jump written; ctr = 11 if jump, else 10 (weakly taken).
- Miss, not taken: no allocation; table unchanged.

Counters:
- perf_branches +1 per update cycle.
- perf_mispredicts +1 when mispredict_e=1.
- Both saturate at 32'hFFFFFFFF; they do not wrap.

Simultaneous lookup and update to the same index: the lookup returns pre-update state (read-before-write). No bypass.

Reset (async, any time including mid-update):
- All valid <= 0, all ctr <= 01, perf counters <= 0.
- Tags and targets need no reset.
- Outputs immediately become pred_taken_f=0, pred_pc_f=pc_f+4, perf_*=0; mispredict_e follows its inputs.
- The first update after reset deassertion is applied normally.

Latency:
- Prediction is 0 cycles after pc_f.
- A training update is visible to lookups from the cycle after the update edge.

Decomposition:
- Shared package bp_pkg: counter encodings (SNT=00, WNT=01, WT=10, ST=11), btb_entry_t struct (valid, tag, target, is_jump, ctr), and a sat_inc/sat_dec function pair.
- One natural sub-module, bp_sat_counter32, for the saturating perf counter (instantiated twice).
- The table stays a flop array in branch_predictor.

Test Plan:
1. Reset: rst_n=0 for 1 cycle, then pc_f=0x100 -> pred_taken_f=0, pred_pc_f=0x104; perf_branches=0.
2. Allocate conditional branch: update pc=0x100, taken=1, target=0x80, pred_taken_e=0 -> mispredict_e=1, redirect_pc_e=0x80. Next cycle lookup 0x100 -> pred_taken_f=1, pred_pc_f=0x80 (ctr=10).
3. Training and hysteresis on 0x100:
   - Two not-taken updates -> ctr 10->01->00; lookup gives pred_taken_f=0.
   - One taken update -> ctr 01; lookup still pred_taken_f=0.
   - Then a second taken update -> ctr 10; lookup gives pred_taken_f=1.
   - Further taken updates saturate at 11.
4. Alias/replace (ENTRIES=16): pc=0x100 then pc=0x140 (same index, different tag). Taken update for 0x140, target 0x200 -> lookup 0x100 misses (pc+4=0x104); lookup 0x140 gives 0x200.
5. Jump and wrong-target: jal at 0x20, target 0x400, allocated with ctr=11. Then update with pred_taken_e=1, pred_pc_e=0x400, upd_target_e=0x404 -> mispredict_e=1, redirect_pc_e=0x404, target overwritten. Same-cycle lookup of 0x20 still returns 0x400.
6. Async reset mid-update: assert rst_n=0 between clock edges while upd_valid_e=1 -> table is invalid immediately. Subsequent lookup of a trained PC gives not-taken; perf_mispredicts=0.
